branch_resolve_bht: RTL and testbench

Parametrised branch resolution unit for the next core revision. It extends the existing combinational compare-and-take logic with four additions:
- a registered resolve stage;
- mispredict detection and redirect-PC generation;
- a 2-bit saturating branch history table (BHT) for fetch-time prediction;
- saturating statistics counters.

It sits between decode/execute (resolve side) and fetch (predict side).

---
 rtl/br_pkg.sv | 29 ++
 rtl/br_cond.sv | 46 ++++
 rtl/branch_resolve_bht.sv | 153 +++++++++++++++
 tb/tb_branch_resolve_bht.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared branch-type codes, 2-bit counter states and saturating update
// Purpose : constants and the saturating-counter helper used by branch_resolve_bht and br_cond.
// Contents: BR_* branch type codes, SNT/WNT/WT/ST counter states, sat2_next().
package br_pkg;

   localparam logic [2:0] BR_NO  = 3'b000;
   localparam logic [2:0] BR_LTU = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b010;
   localparam logic [2:0] BR_EQ  = 3'b011;
   localparam logic [2:0] BR_GEU = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_NEQ = 3'b110;
   localparam logic [2:0] BR_RSV = 3'b111;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Next state of a 2-bit saturating counter: taken counts up, not-taken counts down.
   function automatic logic [1:0] sat2_next(input logic [1:0] cur, input logic taken);
      if (taken) begin
         return (cur == ST) ? ST : cur + 2'd1;
      end else begin
         return (cur == SNT) ? SNT : cur - 2'd1;
      end
   endfunction

endpackage

// File: rtl/br_cond.sv
// rtl/br_cond.sv - combinational branch compare and taken decode
// Purpose : evaluates the branch condition for one instruction.
// Ports   : rs1_i, rs2_i   operands
//           br_type_i      branch type (br_pkg encoding)
//           taken_o        condition true for a conditional branch type
//           cond_br_o      br_type_i is a conditional branch (001..110)
//           illegal_o      br_type_i is the reserved code
module br_cond
   import br_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [2:0]      br_type_i,
   output logic            taken_o,
   output logic            cond_br_o,
   output logic            illegal_o
);

   logic eq;
   logic lt;
   logic ltu;

   // Only three comparators; the other three types are their complements.
   assign eq  = (rs1_i == rs2_i);
   assign lt  = ($signed(rs1_i) < $signed(rs2_i));
   assign ltu = (rs1_i < rs2_i);

   always_comb begin
      taken_o = 1'b0;
      case (br_type_i)
         BR_LTU:  taken_o = ltu;
         BR_LT:   taken_o = lt;
         BR_EQ:   taken_o = eq;
         BR_GEU:  taken_o = ~ltu;
         BR_GE:   taken_o = ~lt;
         BR_NEQ:  taken_o = ~eq;
         default: taken_o = 1'b0;
      endcase
   end

   assign cond_br_o = (br_type_i != BR_NO) && (br_type_i != BR_RSV);
   assign illegal_o = (br_type_i == BR_RSV);

endmodule

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - registered branch resolve with mispredict redirect, BHT and stats
// Purpose : resolves branches one cycle after request, generates the redirect PC, trains a
//           2-bit BHT used by fetch, and keeps saturating branch/mispredict counters.
// Ports   : clk, rst_n                          clock, synchronous active-low reset
//           pred_valid, pred_pc                 fetch lookup request
//           pred_out_valid, pred_out_taken      lookup result (one cycle later)
//           res_valid, res_pc, rs1, rs2,        resolve request
//           br_type, res_target, res_pred_taken
//           out_valid, out_taken, out_mispredict,
//           out_redirect_pc, out_illegal        resolve result (one cycle later)
//           stat_clr, cnt_branch, cnt_mispredict statistics
module branch_resolve_bht
   import br_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pred_valid,
   input  logic [XLEN-1:0]  pred_pc,
   output logic             pred_out_valid,
   output logic             pred_out_taken,
   input  logic             res_valid,
   input  logic [XLEN-1:0]  res_pc,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   input  logic [2:0]       br_type,
   input  logic [XLEN-1:0]  res_target,
   input  logic             res_pred_taken,
   output logic             out_valid,
   output logic             out_taken,
   output logic             out_mispredict,
   output logic [XLEN-1:0]  out_redirect_pc,
   output logic             out_illegal,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] cnt_branch,
   output logic [CNT_W-1:0] cnt_mispredict
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [IDX_W-1:0] pred_idx;
   logic [IDX_W-1:0] res_idx;

   logic             taken;
   logic             cond_br;
   logic             illegal;
   logic             mispredict;
   logic             upd;
   logic [XLEN-1:0]  redirect_d;

   logic             pred_out_valid_q;
   logic             pred_out_taken_q;
   logic             out_valid_q;
   logic             out_taken_q;
   logic             out_mispredict_q;
   logic [XLEN-1:0]  out_redirect_pc_q;
   logic             out_illegal_q;
   logic [CNT_W-1:0] cnt_branch_q;
   logic [CNT_W-1:0] cnt_branch_d;
   logic [CNT_W-1:0] cnt_mispredict_q;
   logic [CNT_W-1:0] cnt_mispredict_d;

   // Only the index bits of the lookup PC matter; the rest are deliberately dropped.
   logic unused_pred_pc_bits;
   assign unused_pred_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

   assign pred_idx = pred_pc[IDX_W+1:2];
   assign res_idx  = res_pc[IDX_W+1:2];

   br_cond #(.XLEN(XLEN)) u_cond (
      .rs1_i     (rs1),
      .rs2_i     (rs2),
      .br_type_i (br_type),
      .taken_o   (taken),
      .cond_br_o (cond_br),
      .illegal_o (illegal)
   );

   // Non-branches resolve as not-taken, so a predicted-taken non-branch still redirects.
   assign mispredict = taken ^ res_pred_taken;
   assign upd        = res_valid & cond_br;
   assign redirect_d = taken ? res_target : res_pc + XLEN'(4);

   // Clear beats a same-cycle increment; increments stop at all-ones.
   always_comb begin
      cnt_branch_d     = cnt_branch_q;
      cnt_mispredict_d = cnt_mispredict_q;
      if (stat_clr) begin
         cnt_branch_d     = '0;
         cnt_mispredict_d = '0;
      end else if (upd) begin
         if (cnt_branch_q != '1) begin
            cnt_branch_d = cnt_branch_q + CNT_W'(1);
         end
         if (mispredict && (cnt_mispredict_q != '1)) begin
            cnt_mispredict_d = cnt_mispredict_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pred_out_valid_q  <= 1'b0;
         pred_out_taken_q  <= 1'b0;
         out_valid_q       <= 1'b0;
         out_taken_q       <= 1'b0;
         out_mispredict_q  <= 1'b0;
         out_redirect_pc_q <= '0;
         out_illegal_q     <= 1'b0;
         cnt_branch_q      <= '0;
         cnt_mispredict_q  <= '0;
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= WNT;
         end
      end else begin
         // Lookup reads the array before this edge's update: read-old on collision.
         pred_out_valid_q <= pred_valid;
         if (pred_valid) begin
            pred_out_taken_q <= bht_q[pred_idx][1];
         end

         out_valid_q      <= res_valid;
         out_mispredict_q <= res_valid & mispredict;
         out_illegal_q    <= res_valid & illegal;
         if (res_valid) begin
            out_taken_q       <= taken;
            out_redirect_pc_q <= redirect_d;
         end

         if (upd) begin
            bht_q[res_idx] <= sat2_next(bht_q[res_idx], taken);
         end

         cnt_branch_q     <= cnt_branch_d;
         cnt_mispredict_q <= cnt_mispredict_d;
      end
   end

   assign pred_out_valid  = pred_out_valid_q;
   assign pred_out_taken  = pred_out_taken_q;
   assign out_valid       = out_valid_q;
   assign out_taken       = out_taken_q;
   assign out_mispredict  = out_mispredict_q;
   assign out_redirect_pc = out_redirect_pc_q;
   assign out_illegal     = out_illegal_q;
   assign cnt_branch      = cnt_branch_q;
   assign cnt_mispredict  = cnt_mispredict_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - directed scoreboard bench for branch_resolve_bht
module tb_branch_resolve_bht;

   localparam int XLEN        = 32;
   localparam int BHT_ENTRIES = 64;
   localparam int CNT_W       = 4;
   localparam int IDX_W       = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             pred_valid;
   logic [XLEN-1:0]  pred_pc;
   logic             pred_out_valid;
   logic             pred_out_taken;
   logic             res_valid;
   logic [XLEN-1:0]  res_pc;
   logic [XLEN-1:0]  rs1;
   logic [XLEN-1:0]  rs2;
   logic [2:0]       br_type;
   logic [XLEN-1:0]  res_target;
   logic             res_pred_taken;
   logic             out_valid;
   logic             out_taken;
   logic             out_mispredict;
   logic [XLEN-1:0]  out_redirect_pc;
   logic             out_illegal;
   logic             stat_clr;
   logic [CNT_W-1:0] cnt_branch;
   logic [CNT_W-1:0] cnt_mispredict;

   always #5 clk = ~clk;

   branch_resolve_bht #(.XLEN(XLEN), .BHT_ENTRIES(BHT_ENTRIES), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pred_valid      (pred_valid),
      .pred_pc         (pred_pc),
      .pred_out_valid  (pred_out_valid),
      .pred_out_taken  (pred_out_taken),
      .res_valid       (res_valid),
      .res_pc          (res_pc),
      .rs1             (rs1),
      .rs2             (rs2),
      .br_type         (br_type),
      .res_target      (res_target),
      .res_pred_taken  (res_pred_taken),
      .out_valid       (out_valid),
      .out_taken       (out_taken),
      .out_mispredict  (out_mispredict),
      .out_redirect_pc (out_redirect_pc),
      .out_illegal     (out_illegal),
      .stat_clr        (stat_clr),
      .cnt_branch      (cnt_branch),
      .cnt_mispredict  (cnt_mispredict)
   );

   typedef struct packed {
      logic            taken;
      logic            mis;
      logic [XLEN-1:0] rd;
      logic            ill;
   } res_t;

   res_t             rq[$];
   logic             pq[$];
   logic [1:0]       m_bht [BHT_ENTRIES];
   logic [CNT_W-1:0] m_cb;
   logic [CNT_W-1:0] m_cm;
   logic             upd_pend;
   logic             mis_pend;
   logic             last_taken;
   logic [XLEN-1:0]  last_rd;
   logic             last_pt;
   int               n_assert = 0;
   int               n_fail   = 0;

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic cond(input logic [2:0] bt, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
      case (bt)
         3'd1:    return a < b;
         3'd2:    return $signed(a) < $signed(b);
         3'd3:    return a == b;
         3'd4:    return a >= b;
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a != b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic idle_inputs();
      pred_valid     = 1'b0;
      res_valid      = 1'b0;
      stat_clr       = 1'b0;
      br_type        = 3'd0;
      res_pred_taken = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 2'b01;
      m_cb       = '0;
      m_cm       = '0;
      upd_pend   = 1'b0;
      mis_pend   = 1'b0;
      last_taken = 1'b0;
      last_rd    = '0;
      last_pt    = 1'b0;
      rq.delete();
      pq.delete();
   endtask

   task automatic set_pred(input logic [XLEN-1:0] pc);
      logic [XLEN-1:0] p;
      p          = pc;
      pred_valid = 1'b1;
      pred_pc    = pc;
      pq.push_back(m_bht[p[IDX_W+1:2]][1]);
   endtask

   task automatic set_res(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [2:0] bt,
                          input logic [XLEN-1:0] tgt, input logic pt);
      res_t            e;
      logic [XLEN-1:0] p;
      logic [IDX_W-1:0] ix;
      logic            is_br;
      p              = pc;
      ix             = p[IDX_W+1:2];
      res_valid      = 1'b1;
      res_pc         = pc;
      rs1            = a;
      rs2            = b;
      br_type        = bt;
      res_target     = tgt;
      res_pred_taken = pt;
      is_br          = (bt >= 3'd1) && (bt <= 3'd6);
      e.taken        = is_br && cond(bt, a, b);
      e.mis          = e.taken ^ pt;
      e.rd           = e.taken ? tgt : pc + 32'd4;
      e.ill          = (bt == 3'd7);
      rq.push_back(e);
      if (is_br) begin
         if (e.taken) m_bht[ix] = (m_bht[ix] == 2'b11) ? 2'b11 : m_bht[ix] + 2'd1;
         else         m_bht[ix] = (m_bht[ix] == 2'b00) ? 2'b00 : m_bht[ix] - 2'd1;
         upd_pend = 1'b1;
         mis_pend = e.mis;
      end
   endtask

   task automatic tick();
      res_t e;
      logic pt;
      if (stat_clr) begin
         m_cb = '0;
         m_cm = '0;
      end else if (upd_pend) begin
         if (m_cb != 4'hF) m_cb = m_cb + 4'd1;
         if (mis_pend && m_cm != 4'hF) m_cm = m_cm + 4'd1;
      end
      upd_pend = 1'b0;
      mis_pend = 1'b0;
      @(posedge clk);
      #1;
      if (rq.size() > 0) begin
         e = rq.pop_front();
         chk("out_valid", out_valid, 1);
         chk("out_taken", out_taken, e.taken);
         chk("out_mispredict", out_mispredict, e.mis);
         chk("out_redirect_pc", out_redirect_pc, e.rd);
         chk("out_illegal", out_illegal, e.ill);
         last_taken = e.taken;
         last_rd    = e.rd;
      end else begin
         chk("out_valid_idle", out_valid, 0);
         chk("out_mispredict_idle", out_mispredict, 0);
         chk("out_illegal_idle", out_illegal, 0);
         chk("out_taken_hold", out_taken, last_taken);
         chk("out_redirect_hold", out_redirect_pc, last_rd);
      end
      if (pq.size() > 0) begin
         pt = pq.pop_front();
         chk("pred_out_valid", pred_out_valid, 1);
         chk("pred_out_taken", pred_out_taken, pt);
         last_pt = pt;
      end else begin
         chk("pred_out_valid_idle", pred_out_valid, 0);
         chk("pred_out_taken_hold", pred_out_taken, last_pt);
      end
      chk("cnt_branch", cnt_branch, m_cb);
      chk("cnt_mispredict", cnt_mispredict, m_cm);
      idle_inputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_taken", out_taken, 0);
      chk("rst_out_mispredict", out_mispredict, 0);
      chk("rst_out_redirect", out_redirect_pc, 0);
      chk("rst_out_illegal", out_illegal, 0);
      chk("rst_pred_out_valid", pred_out_valid, 0);
      chk("rst_pred_out_taken", pred_out_taken, 0);
      chk("rst_cnt_branch", cnt_branch, 0);
      chk("rst_cnt_mispredict", cnt_mispredict, 0);
      model_reset();
      rst_n = 1'b1;
      idle_inputs();
   endtask

   initial begin
      rst_n      = 1'b0;
      pred_pc    = '0;
      res_pc     = '0;
      rs1        = '0;
      rs2        = '0;
      res_target = '0;
      idle_inputs();
      model_reset();
      do_reset();
      do_reset();

      // Lookup straight after reset: weakly not-taken.
      set_pred(32'h1000);
      tick();
      chk("t1_pred_taken", pred_out_taken, 0);
      chk("t1_cnt_branch", cnt_branch, 0);

      // Signed vs unsigned less-than on the same operands.
      set_res(32'h1000, 32'hFFFF_FFFF, 32'd1, 3'b010, 32'h2000, 1'b0);
      tick();
      chk("t2_blt_redirect", out_redirect_pc, 32'h2000);
      chk("t2_blt_mispredict", out_mispredict, 1);
      set_res(32'h1000, 32'hFFFF_FFFF, 32'd1, 3'b001, 32'h2000, 1'b0);
      tick();
      chk("t2_bltu_redirect", out_redirect_pc, 32'h1004);
      chk("t2_bltu_taken", out_taken, 0);

      // BHT training with read-old collision on the first update.
      set_pred(32'h1008);
      set_res(32'h1008, 32'd5, 32'd5, 3'b011, 32'h3000, 1'b0);
      tick();
      chk("t3_collision_read_old", pred_out_taken, 0);
      set_res(32'h1008, 32'd5, 32'd5, 3'b011, 32'h3000, 1'b1);
      tick();
      set_pred(32'h1008);
      set_res(32'h1008, 32'd5, 32'd5, 3'b011, 32'h3000, 1'b1);
      tick();
      chk("t3_pred_after_two", pred_out_taken, 1);
      tick();

      // Reserved type: illegal, never taken, no training or counting.
      set_res(32'h1010, 32'd0, 32'd0, 3'b111, 32'h4000, 1'b1);
      tick();
      chk("t4_illegal", out_illegal, 1);
      chk("t4_rsv_mispredict", out_mispredict, 1);
      chk("t4_rsv_redirect", out_redirect_pc, 32'h1014);
      set_pred(32'h1010);
      tick();
      set_res(32'hFFFF_FFFC, 32'd1, 32'd2, 3'b011, 32'h5000, 1'b0);
      tick();
      chk("t4_wrap_redirect", out_redirect_pc, 32'h0000_0000);

      // Back-to-back mixed traffic covering every branch type.
      for (int i = 0; i < 40; i++) begin
         logic [XLEN-1:0] opnd [4];
         opnd[0] = 32'h0;
         opnd[1] = 32'h7FFF_FFFF;
         opnd[2] = 32'h8000_0000;
         opnd[3] = 32'hFFFF_FFFF;
         if ($urandom_range(0, 1) == 1) set_pred(32'h2000 + 32'($urandom_range(0, 3)) * 4);
         set_res(32'h2000 + 32'($urandom_range(0, 3)) * 4, opnd[$urandom_range(0, 3)],
                 opnd[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 32'h6000,
                 1'($urandom_range(0, 1)));
         tick();
      end

      // Saturation of 4-bit counters, then clear beating a same-cycle branch.
      for (int i = 0; i < 20; i++) begin
         set_res(32'h1020, 32'd7, 32'd7, 3'b011, 32'h7000, 1'b0);
         tick();
      end
      chk("t5_cnt_branch_sat", cnt_branch, 4'hF);
      chk("t5_cnt_mispredict_sat", cnt_mispredict, 4'hF);
      stat_clr = 1'b1;
      set_res(32'h1020, 32'd7, 32'd7, 3'b011, 32'h7000, 1'b0);
      tick();
      chk("t5_clr_branch", cnt_branch, 0);
      chk("t5_clr_mispredict", cnt_mispredict, 0);

      // Reset after a resolve restores the trained entry to weakly not-taken.
      set_res(32'h1030, 32'd1, 32'd1, 3'b011, 32'h8000, 1'b0);
      tick();
      do_reset();
      set_pred(32'h1030);
      tick();
      set_res(32'h1030, 32'd1, 32'd1, 3'b011, 32'h8000, 1'b0);
      tick();
      set_pred(32'h1030);
      tick();
      chk("t6_entry_from_wnt", pred_out_taken, 1);

      // Resolve in the same cycle as reset is discarded.
      set_res(32'h1040, 32'd1, 32'd1, 3'b011, 32'h9000, 1'b1);
      do_reset();
      set_pred(32'h1040);
      tick();
      chk("t6_discarded_update", pred_out_taken, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
